data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the single-cycle core's load/store datapath and a variable-latency, line-granular backing memory. It takes one word access at a time from the core and stalls the core via `is_ready` while it serves misses. It reports hit or miss per access and keeps hit and miss counters for performance measurement.

## Interface
- `NUM_SETS`, 16: number of lines; power of two, ≥2. Line is fixed at 4 words (16 bytes).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `is_input_valid` input 1: core request present.
- `addr` input 32: byte address, word-aligned; `addr[1:0]` ignored.
- `mem_read` input 1: load request.
- `mem_write` input 1: store request; wins if both are set.
- `din` input 32: store data.
- `is_ready` output 1: cache can accept a request this cycle.
- `is_output_valid` output 1: access completes this cycle.
- `dout` output 32: load data; 0 whenever `is_output_valid`=0.
- `is_hit` output 1: the completing access hit; 0 whenever `is_output_valid`=0.
- `mem_req_valid` output 1: backing-memory request.
- `mem_req_write` output 1: 1 = line writeback, 0 = line fill.
- `mem_req_addr` output 32: line-aligned address (`[3:0]`=0).
- `mem_req_data` output 128: writeback line; word k at `[32k+31:32k]`.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_resp_valid` input 1: fill data present (1 cycle).
- `mem_resp_data` input 128: fill line, same word order.
- `hit_count` output 32: completed hits since reset.
- `miss_count` output 32: completed misses since reset.

## Operation
- Address split: word offset `addr[3:2]`, index `addr[3+log2(NUM_SETS):4]`, tag is the remaining upper bits.
- Per line: valid bit, dirty bit, tag, 128-bit data. Reset clears every valid and dirty bit. Tag and data arrays are not reset.
- Accept: at a rising edge where `is_ready` and `is_input_valid` and (`mem_read` or `mem_write`). The cache latches `addr`, `din` and the write flag. `is_input_valid` with neither `mem_read` nor `mem_write` set is not accepted.
- FSM states: IDLE, COMPARE, WB_REQ, FILL_REQ, FILL_WAIT. `is_ready` = (state==IDLE) and not `reset`.
- IDLE: on accept, clear the miss flag and go to COMPARE.
- COMPARE, hit (valid and tag match):
  - assert `is_output_valid`; `is_hit` = not miss flag; `dout` = the addressed word.
  - on a store, write `din` into that word and set dirty at the edge.
  - increment `hit_count` if the miss flag is clear, otherwise `miss_count`; go to IDLE.
- COMPARE, miss: set the miss flag. Go to WB_REQ if the victim is valid and dirty, otherwise to FILL_REQ. No outputs are asserted.
- WB_REQ: `mem_req_valid`=1, `mem_req_write`=1. `mem_req_addr` = {victim tag, index, 4'b0}; `mem_req_data` = victim line. On `mem_req_ready`, go to FILL_REQ. Writebacks return no response.
- FILL_REQ: `mem_req_valid`=1, `mem_req_write`=0, `mem_req_addr` = {addr[31:4], 4'b0}. On `mem_req_ready`, go to FILL_WAIT.
- FILL_WAIT: on `mem_resp_valid`, write the line and set valid=1, dirty=0, tag = request tag. Go to COMPARE, which now hits and completes with `is_hit`=0.
- `mem_resp_valid` outside FILL_WAIT is ignored. Memory serves requests in order.
- Counters wrap modulo 2^32.

## Timing
- Reset (asynchronous, takes effect immediately and mid-operation): state IDLE; `is_output_valid`, `is_hit`, `dout`, `mem_req_valid`, `mem_req_write`, `mem_req_addr`, `mem_req_data` = 0; counters 0; all lines invalid. An in-flight access is dropped.
- Hit latency: accepted at edge N, `is_output_valid`=1 during cycle N+1, `is_ready`=1 again in cycle N+2.
- Clean miss: COMPARE (1) + FILL_REQ (≥1, until ready) + FILL_WAIT (≥1, until response) + COMPARE (1). Dirty miss adds WB_REQ (≥1).
- `mem_req_*` stay stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- A request is granted at the edge where `mem_req_valid` and `mem_req_ready` are both 1. A fill can complete no earlier than the cycle after that grant.

## Test plan
- Cold read: reset, then load 0x10. Fill request for addr 0x10 appears. Respond with words {4,3,2,1} (word0=1). Completion has `is_hit`=0, `dout`=1, `miss_count`=1.
- Hit read: load 0x14 right after. `is_output_valid`=1 one cycle after accept, `is_hit`=1, `dout`=2, `hit_count`=1, no memory request.
- Store hit then read: store 0xDEADBEEF to 0x18 (`is_hit`=1), then load 0x18. `dout`=0xDEADBEEF, no memory traffic.
- Dirty conflict (NUM_SETS=16): load 0x110. Writeback of addr 0x10 comes first, with data word2=0xDEADBEEF, word0=1. Then a fill of 0x110, then completion with `is_hit`=0.
- Backpressure: hold `mem_req_ready`=0 for 5 cycles during FILL_REQ. `mem_req_valid`, `mem_req_addr` and `mem_req_data` hold stable, `is_ready`=0, and one request is granted on the first ready cycle.
- Reset in FILL_WAIT: assert `reset` mid-miss. State goes to IDLE immediately and outputs go to 0. A late `mem_resp_valid` is ignored, and a subsequent load of 0x10 misses.

Source files
------------

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-back, write-allocate data cache with 4-word (16-byte)
//   lines. It sits between the core's load/store port and a variable-latency,
//   line-granular backing memory. It serves one word access at a time and
//   stalls the core through is_ready while a miss is being handled.
//
// Ports
//   clk, reset          : clock; asynchronous active-high reset
//   is_input_valid      : core request present
//   addr, mem_read,     : word-aligned byte address, load flag,
//   mem_write, din      : store flag (wins over load) and store data
//   is_ready            : a request can be accepted this cycle
//   is_output_valid     : the accepted access completes this cycle
//   dout, is_hit        : load data and hit flag (both 0 when not completing)
//   mem_req_*           : line request to memory (writeback or fill)
//   mem_req_ready       : memory accepts the current request
//   mem_resp_valid/data : one-cycle fill response carrying a whole line
//   hit_count,          : completed hits and misses since reset
//   miss_count
module data_cache #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_req_valid,
  output logic         mem_req_write,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, WB_REQ, FILL_REQ, FILL_WAIT} state_t;

  state_t              state_q, state_d;
  logic [31:2]         addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                write_q, write_d;
  logic                miss_q, miss_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;

  // Tag and data arrays carry no reset; the valid bits guard them.
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];

  logic [IDX_W-1:0]    idx;
  logic [1:0]          off;
  logic [TAG_W-1:0]    req_tag;
  logic [127:0]        line;
  logic [31:0]         word;
  logic                lookup_hit;
  logic                accept;
  logic                store_hit;
  logic                fill_done;

  // The byte-offset bits of the core address carry no information.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // All lookups work on the latched request, never on the live core address.
  assign idx        = addr_q[IDX_W+3:4];
  assign off        = addr_q[3:2];
  assign req_tag    = addr_q[31:IDX_W+4];
  assign line       = data_q[idx];
  assign word       = line[{off, 5'b0} +: 32];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == req_tag);

  assign accept    = (state_q == IDLE) && is_input_valid && (mem_read || mem_write);
  assign store_hit = (state_q == COMPARE) && lookup_hit && write_q;
  assign fill_done = (state_q == FILL_WAIT) && mem_resp_valid;

  // Outputs decode the registered state and arrays only, so they hold steady
  // for a whole cycle and fall to zero the moment reset forces IDLE.
  assign is_ready        = (state_q == IDLE) && !reset;
  assign is_output_valid = (state_q == COMPARE) && lookup_hit;
  assign is_hit          = is_output_valid && !miss_q;
  assign dout            = is_output_valid ? word : 32'd0;
  assign mem_req_valid   = (state_q == WB_REQ) || (state_q == FILL_REQ);
  assign mem_req_write   = (state_q == WB_REQ);
  assign mem_req_data    = (state_q == WB_REQ) ? line : 128'd0;
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

  // A writeback targets the victim's own line; a fill targets the request.
  always_comb begin
    mem_req_addr = 32'd0;
    if (state_q == WB_REQ) begin
      mem_req_addr = {tag_q[idx], idx, 4'b0};
    end else if (state_q == FILL_REQ) begin
      mem_req_addr = {addr_q[31:4], 4'b0};
    end
  end

  // Next-state logic. The miss flag remembers that the current access has
  // already missed, so the final COMPARE after a fill completes as a miss.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    din_d        = din_q;
    write_d      = write_q;
    miss_d       = miss_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = addr[31:2];
          din_d   = din;
          write_d = mem_write;
          miss_d  = 1'b0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (lookup_hit) begin
          if (write_q) begin
            dirty_d[idx] = 1'b1;
          end
          if (miss_q) begin
            miss_count_d = miss_count_q + 32'd1;
          end else begin
            hit_count_d = hit_count_q + 32'd1;
          end
          state_d = IDLE;
        end else begin
          miss_d  = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        if (mem_req_ready) begin
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        if (mem_req_ready) begin
          state_d = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset drops any in-flight access and invalidates all lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      din_q        <= '0;
      write_q      <= 1'b0;
      miss_q       <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      write_q      <= write_d;
      miss_q       <= miss_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Line storage: a fill replaces the whole line and its tag, a store hit
  // overwrites one word. Both enables are gated by state, which reset holds
  // at IDLE, so no write happens while reset is asserted.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[idx] <= mem_resp_data;
      tag_q[idx]  <= req_tag;
    end else if (store_hit) begin
      data_q[idx][{off, 5'b0} +: 32] <= din_q;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Directed bench for data_cache (NUM_SETS = 16). Stimulus pushes the
//   expected completions and memory requests into queues; a completion
//   monitor and the memory responder pop and compare them independently.
module tb_data_cache;

  localparam int NUM_SETS = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  din = '0;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] dout;
    logic        hit;
  } compExp_t;

  typedef struct packed {
    logic         write;
    logic [31:0]  addr;
    logic [127:0] data;
  } memExp_t;

  compExp_t     compQ[$];
  memExp_t      memQ[$];
  logic [127:0] memModel [logic [31:0]];

  int          stallLeft = 0;
  int          respDelay = 0;
  int          grantCount = 0;
  logic        respPending = 1'b0;
  int          respCountdown = 0;
  logic [31:0] respAddr = '0;

  data_cache #(.NUM_SETS(NUM_SETS)) dut (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (is_input_valid),
    .addr           (addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .din            (din),
    .is_ready       (is_ready),
    .is_output_valid(is_output_valid),
    .dout           (dout),
    .is_hit         (is_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic checkCounters(input logic [31:0] expHits, input logic [31:0] expMisses);
    checkOutput("hit_count", hit_count, expHits);
    checkOutput("miss_count", miss_count, expMisses);
  endtask

  task automatic pushMem(input logic write, input logic [31:0] a, input logic [127:0] d);
    memExp_t e;
    e.write = write;
    e.addr  = a;
    e.data  = d;
    memQ.push_back(e);
  endtask

  // Presents one request and holds it until the edge that accepts it.
  task automatic issueRequest(input logic isWrite, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!is_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("is_ready before issue", is_ready, 1);
    is_input_valid = 1'b1;
    mem_read       = !isWrite;
    mem_write      = isWrite;
    addr           = a;
    din            = d;
    @(posedge clk);
    #1;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
  endtask

  // Returns the number of cycles from the accept edge to completion.
  task automatic waitDone(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!is_output_valid && lat < 200);
    checkOutput("completion seen", is_output_valid, 1);
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expDout, input logic expHit, output int lat);
    compExp_t e;
    e.dout = expDout;
    e.hit  = expHit;
    compQ.push_back(e);
    issueRequest(isWrite, a, d);
    waitDone(lat);
  endtask

  // Completion monitor: pops one expectation per completing access and
  // requires quiet outputs on every other cycle.
  always @(negedge clk) begin : completionMonitor
    compExp_t e;
    if (is_output_valid) begin
      if (compQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected completion: dout %0h is_hit %0b", dout, is_hit);
      end else begin
        e = compQ.pop_front();
        checkOutput("dout", dout, e.dout);
        checkOutput("is_hit", is_hit, e.hit);
      end
    end else if (!reset) begin
      checkOutput("quiet dout/is_hit", {dout, is_hit}, 0);
    end
  end

  // Backing memory: optionally stalls, checks request stability while
  // stalled, compares each granted request against the expectation queue,
  // applies writebacks and answers fills after respDelay cycles.
  initial begin : responder
    logic    holding;
    memExp_t snap;
    memExp_t e;
    holding        = 1'b0;
    snap           = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        holding       = 1'b0;
        grantCount++;
        if (snap.write) begin
          memModel[snap.addr] = snap.data;
        end else begin
          respPending   = 1'b1;
          respAddr      = snap.addr;
          respCountdown = respDelay;
        end
      end
      if (respPending) begin
        if (respCountdown == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = memModel.exists(respAddr) ? memModel[respAddr] : 128'd0;
          respPending    = 1'b0;
        end else begin
          respCountdown--;
        end
      end
      if (mem_req_valid && !reset) begin
        if (!holding) begin
          holding    = 1'b1;
          snap.write = mem_req_write;
          snap.addr  = mem_req_addr;
          snap.data  = mem_req_data;
        end else begin
          checkOutput("mem_req stable under backpressure",
                      {mem_req_valid, mem_req_write, mem_req_addr, mem_req_data}, {1'b1, snap});
        end
        if (stallLeft > 0) begin
          stallLeft--;
          checkOutput("is_ready during miss", is_ready, 0);
        end else begin
          mem_req_ready = 1'b1;
          if (memQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected mem request: write %0b addr %0h", mem_req_write, mem_req_addr);
          end else begin
            e = memQ.pop_front();
            checkOutput("mem_req_write", mem_req_write, e.write);
            checkOutput("mem_req_addr", mem_req_addr, e.addr);
            if (e.write) begin
              checkOutput("mem_req_data", mem_req_data, e.data);
            end
          end
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int lat;
    int g;
    int n;
    memModel[32'h0000_0010] = 128'h00000004_00000003_00000002_00000001;
    memModel[32'h0000_0110] = 128'h00000080_00000070_00000060_00000050;
    memModel[32'h0000_0210] = 128'h00000033_00000022_00000011_00000000;
    memModel[32'h0000_0310] = 128'h0000000d_0000000c_0000000b_0000000a;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("is_ready after reset", is_ready, 1);
    checkOutput("is_output_valid after reset", is_output_valid, 0);
    checkOutput("mem_req_valid after reset", mem_req_valid, 0);
    checkCounters(0, 0);

    $display("[TB] cold read 0x10");
    pushMem(1'b0, 32'h10, '0);
    applyStimulus(1'b0, 32'h10, 32'd0, 32'd1, 1'b0, lat);
    @(negedge clk);
    checkCounters(0, 1);

    $display("[TB] hit read 0x14");
    applyStimulus(1'b0, 32'h14, 32'd0, 32'd2, 1'b1, lat);
    checkOutput("hit latency", lat, 1);
    @(negedge clk);
    checkOutput("is_ready after hit", is_ready, 1);
    checkCounters(1, 1);

    $display("[TB] store hit then read 0x18");
    applyStimulus(1'b1, 32'h18, 32'hDEADBEEF, 32'd3, 1'b1, lat);
    @(negedge clk);
    checkCounters(2, 1);
    applyStimulus(1'b0, 32'h18, 32'd0, 32'hDEADBEEF, 1'b1, lat);
    @(negedge clk);
    checkCounters(3, 1);

    $display("[TB] dirty conflict 0x110");
    pushMem(1'b1, 32'h10, 128'h00000004_DEADBEEF_00000002_00000001);
    pushMem(1'b0, 32'h110, '0);
    applyStimulus(1'b0, 32'h110, 32'd0, 32'h50, 1'b0, lat);
    @(negedge clk);
    checkCounters(3, 2);

    $display("[TB] backpressure on fill of 0x210");
    g = grantCount;
    pushMem(1'b0, 32'h210, '0);
    stallLeft = 5;
    applyStimulus(1'b0, 32'h21C, 32'd0, 32'h33, 1'b0, lat);
    checkOutput("stall cycles consumed", stallLeft, 0);
    checkOutput("single grant", grantCount - g, 1);
    @(negedge clk);
    checkCounters(3, 3);

    $display("[TB] reset during fill wait");
    respDelay = 20;
    g = grantCount;
    pushMem(1'b0, 32'h310, '0);
    issueRequest(1'b0, 32'h310, 32'd0);
    n = 0;
    while (grantCount == g && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("fill granted", grantCount - g, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("is_ready in reset", is_ready, 0);
    checkOutput("is_output_valid in reset", is_output_valid, 0);
    checkOutput("dout/is_hit in reset", {dout, is_hit}, 0);
    checkOutput("mem_req_valid/write in reset", {mem_req_valid, mem_req_write}, 0);
    checkOutput("mem_req_addr in reset", mem_req_addr, 0);
    checkOutput("mem_req_data in reset", mem_req_data, 0);
    checkCounters(0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    respDelay = 0;
    checkOutput("is_ready after late response", is_ready, 1);
    checkCounters(0, 0);
    pushMem(1'b0, 32'h10, '0);
    applyStimulus(1'b0, 32'h18, 32'd0, 32'hDEADBEEF, 1'b0, lat);
    @(negedge clk);
    checkCounters(0, 1);
    applyStimulus(1'b0, 32'h10, 32'd0, 32'd1, 1'b1, lat);
    @(negedge clk);
    checkCounters(1, 1);

    repeat (3) @(negedge clk);
    checkOutput("completion queue drained", compQ.size(), 0);
    checkOutput("mem request queue drained", memQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
